// File: rtl/prbs_pkg.sv
// Shared types and helpers for the PRBS generator/checker.
// Includes the checker FSM encoding and a wide popcount helper.
package prbs_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    // Widest word the popcount helper accepts; narrower vectors are zero-extended.
    localparam int MAX_DW = 256;
    localparam int PC_W   = 9;

    function automatic logic [PC_W-1:0] popcount(input logic [MAX_DW-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < MAX_DW; i++) begin
            c = c + PC_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/prbs_step.sv
// Combinational one-word LFSR step: DW sequence bits (bit 0 earliest) and next state.
// Zero latency, no flow control.
module prbs_step #(
    parameter int               POL_W = 7,
    parameter logic [POL_W-1:0] TAPS  = 7'b1100000,
    parameter int               DW    = 16
) (
    input  logic [POL_W-1:0] state,
    output logic [DW-1:0]    word,
    output logic [POL_W-1:0] next_state
);

    logic [POL_W-1:0] s;
    logic             fb;

    // s[k-1] holds x(n-k); each iteration emits x(n) and shifts it in at s[0].
    always_comb begin
        s    = state;
        fb   = 1'b0;
        word = '0;
        for (int i = 0; i < DW; i++) begin
            fb      = ^(s & TAPS);
            word[i] = fb;
            s       = {s[POL_W-2:0], fb};
        end
        next_state = s;
    end

endmodule

// File: rtl/prbs_gen_chk.sv
// PRBS word generator (valid/ready, seed load, bit-0 error injection) and self-syncing checker.
// Generator: next word one cycle after accept; checker always ready, results one cycle after in_valid.
module prbs_gen_chk
    import prbs_pkg::*;
#(
    parameter int               POL_W      = 7,
    parameter logic [POL_W-1:0] TAPS       = 7'b1100000,
    parameter int               DW         = 16,
    parameter int               ERR_W      = 16,
    parameter int               LOCK_CNT   = 4,
    parameter int               UNLOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [POL_W-1:0] seed,
    input  logic             inject_err,
    output logic [DW-1:0]    out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic [DW-1:0]    in_data,
    input  logic             in_valid,
    input  logic             err_clr,
    output logic             locked,
    output logic [ERR_W-1:0] err_count,
    output logic             err_word
);

    localparam int          RUN_W   = $clog2(LOCK_CNT + 1);
    localparam int          BAD_W   = $clog2(UNLOCK_CNT + 1);
    localparam logic [32:0] ERR_MAX = 33'({ERR_W{1'b1}});

    // ---------------- generator ----------------
    logic [POL_W-1:0] gen_state;
    logic [POL_W-1:0] gen_next;
    logic [DW-1:0]    gen_word;
    logic [POL_W-1:0] seed_eff;
    logic             inj_pend;
    logic             accept;

    prbs_step #(.POL_W(POL_W), .TAPS(TAPS), .DW(DW)) u_gen_step (
        .state      (gen_state),
        .word       (gen_word),
        .next_state (gen_next)
    );

    assign seed_eff = (seed == '0) ? '1 : seed;
    assign accept   = out_valid & out_ready & ~seed_load;
    // The pending flip is visible on out_data so the consumer sees exactly what it accepts.
    assign out_data = gen_word ^ DW'(inj_pend);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gen_state <= '1;
            out_valid <= 1'b0;
            inj_pend  <= 1'b0;
        end else begin
            out_valid <= 1'b1;
            if (seed_load) begin
                gen_state <= seed_eff;
            end else if (accept) begin
                gen_state <= gen_next;
            end
            inj_pend <= inject_err | (inj_pend & ~accept);
        end
    end

    // ---------------- checker ----------------
    chk_state_t       chk_fsm, chk_fsm_nxt;
    logic [POL_W-1:0] chk_lfsr, chk_lfsr_nxt;
    logic [RUN_W-1:0] run_cnt, run_cnt_nxt, run_inc;
    logic [BAD_W-1:0] bad_cnt, bad_cnt_nxt, bad_inc;
    logic [ERR_W-1:0] err_count_nxt;
    logic             err_word_nxt;
    logic [DW-1:0]    pred_word;
    logic [POL_W-1:0] pred_next;
    logic [POL_W-1:0] hunt_state;
    logic [DW-1:0]    mismatch;
    logic             word_err;
    logic [PC_W-1:0]  pc;
    logic [32:0]      sum;

    prbs_step #(.POL_W(POL_W), .TAPS(TAPS), .DW(DW)) u_chk_step (
        .state      (chk_lfsr),
        .word       (pred_word),
        .next_state (pred_next)
    );

    assign mismatch = in_data ^ pred_word;
    assign word_err = |mismatch;
    assign pc       = popcount(MAX_DW'(mismatch));
    assign run_inc  = run_cnt + RUN_W'(1);
    assign bad_inc  = bad_cnt + BAD_W'(1);
    assign sum      = (err_clr ? 33'd0 : 33'(err_count)) + 33'(pc);
    assign locked   = (chk_fsm == LOCKED);

    always_comb begin
        hunt_state = '0;
        for (int k = 1; k <= POL_W; k++) begin
            hunt_state[k-1] = in_data[DW-k];
        end
    end

    always_comb begin
        chk_fsm_nxt   = chk_fsm;
        chk_lfsr_nxt  = chk_lfsr;
        run_cnt_nxt   = run_cnt;
        bad_cnt_nxt   = bad_cnt;
        err_count_nxt = err_clr ? '0 : err_count;
        err_word_nxt  = 1'b0;
        if (in_valid) begin
            case (chk_fsm)
                HUNT: begin
                    chk_lfsr_nxt = hunt_state;
                    run_cnt_nxt  = '0;
                    chk_fsm_nxt  = VERIFY;
                end
                VERIFY: begin
                    chk_lfsr_nxt = pred_next;
                    if (word_err) begin
                        chk_fsm_nxt = HUNT;
                    end else if (run_inc == RUN_W'(LOCK_CNT)) begin
                        run_cnt_nxt = '0;
                        bad_cnt_nxt = '0;
                        chk_fsm_nxt = LOCKED;
                    end else begin
                        run_cnt_nxt = run_inc;
                    end
                end
                LOCKED: begin
                    // Advance on the prediction so a corrupted word cannot poison later ones.
                    chk_lfsr_nxt  = pred_next;
                    err_count_nxt = (sum > ERR_MAX) ? '1 : sum[ERR_W-1:0];
                    if (word_err) begin
                        err_word_nxt = 1'b1;
                        if (bad_inc == BAD_W'(UNLOCK_CNT)) begin
                            bad_cnt_nxt = '0;
                            chk_fsm_nxt = HUNT;
                        end else begin
                            bad_cnt_nxt = bad_inc;
                        end
                    end else begin
                        bad_cnt_nxt = '0;
                    end
                end
                default: chk_fsm_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_fsm   <= HUNT;
            chk_lfsr  <= '1;
            run_cnt   <= '0;
            bad_cnt   <= '0;
            err_count <= '0;
            err_word  <= 1'b0;
        end else begin
            chk_fsm   <= chk_fsm_nxt;
            chk_lfsr  <= chk_lfsr_nxt;
            run_cnt   <= run_cnt_nxt;
            bad_cnt   <= bad_cnt_nxt;
            err_count <= err_count_nxt;
            err_word  <= err_word_nxt;
        end
    end

endmodule
